riscv_lsu: RTL and testbench

RISCV_LSU -- requirements
Module: riscv_lsu

---
 rtl/riscv_lsu.sv | 171 +++++++++++++++++
 tb/tb_riscv_lsu.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_lsu.sv
// rtl/riscv_lsu.sv - RV32I load/store unit, one outstanding access, IDLE -> ACCESS -> RESP.
// Define LSU_MISALIGN_TRAP_EN to turn misaligned halfword/word accesses into error responses.
module riscv_lsu #(
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic        mem_rstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]    state_q,  state_d;
  logic          store_q,  store_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [31:0]   addr_q,   addr_d;
  logic [31:0]   wdata_q,  wdata_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic [31:0]   rdata_q,  rdata_d;
  logic          err_q,    err_d;

  logic          bad_funct3;
  logic          misalign;
  logic [3:0]    wmask;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;
  logic [31:0]   load_data;

  always_comb begin
    if (req_store) bad_funct3 = req_funct3[2] || (req_funct3[1:0] == 2'b11);
    else           bad_funct3 = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
    misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
               ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
  end

  // Store data is replicated across lanes; the byte mask picks the lane actually written.
  always_comb begin
    case (funct3_q[1:0])
      2'b00: begin
        mem_wdata = {4{wdata_q[7:0]}};
        wmask     = 4'b0001 << addr_q[1:0];
      end
      2'b01: begin
        mem_wdata = {2{wdata_q[15:0]}};
        wmask     = 4'b0011 << {addr_q[1], 1'b0};
      end
      default: begin
        mem_wdata = wdata_q;
        wmask     = 4'b1111;
      end
    endcase
  end

  always_comb begin
    case (addr_q[1:0])
      2'b00:   lane_b = mem_rdata[7:0];
      2'b01:   lane_b = mem_rdata[15:8];
      2'b10:   lane_b = mem_rdata[23:16];
      default: lane_b = mem_rdata[31:24];
    endcase
    lane_h = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_data = {{24{lane_b[7]}}, lane_b};
      3'b001:  load_data = {{16{lane_h[15]}}, lane_h};
      3'b100:  load_data = {24'd0, lane_b};
      3'b101:  load_data = {16'd0, lane_h};
      default: load_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    store_d  = store_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          store_d  = req_store;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          cnt_d    = '0;
          if (bad_funct3 || misalign) begin
            state_d = S_RESP;
            err_d   = 1'b1;
            rdata_d = 32'd0;
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        if (mem_ready) begin
          state_d = S_RESP;
          err_d   = 1'b0;
          rdata_d = store_q ? 32'd0 : load_data;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = S_RESP;
          err_d   = 1'b1;
          rdata_d = 32'd0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        err_d   = 1'b0;
        rdata_d = 32'd0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= S_IDLE;
      store_q  <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      cnt_q    <= '0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      store_q  <= store_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_rstrb = (state_q == S_ACCESS) && !store_q;
  assign mem_wmask = ((state_q == S_ACCESS) && store_q) ? wmask : 4'b0000;

endmodule

// File: tb/tb_riscv_lsu.sv
// tb/tb_riscv_lsu.sv - self-checking bench for riscv_lsu against an arithmetic reference model.
// Expectations follow LSU_MISALIGN_TRAP_EN when the bench is built with it.
module tb_riscv_lsu;

  localparam int TMO = 8;

  logic        CLK;
  logic        RESET;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int checks = 0;
  int errors = 0;

  riscv_lsu #(.TIMEOUT(TMO)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask),
    .mem_rstrb  (mem_rstrb),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit model_bad(input bit st, input int f3, input int unsigned a);
    bit bad;
    bad = st ? (f3 >= 3) : (f3 == 3 || f3 >= 6);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((f3 == 1 || f3 == 5) && (a % 2) == 1) bad = 1'b1;
    if (f3 == 2 && (a % 4) != 0) bad = 1'b1;
`endif
    return bad;
  endfunction

  function automatic int unsigned model_load(input int f3, input int unsigned a, input int unsigned rd);
    int unsigned b;
    int unsigned h;
    b = (rd >> (8 * (a % 4))) & 32'hFF;
    h = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (f3)
      0:       return (b >= 128) ? b - 256 : b;
      1:       return (h >= 32768) ? h - 65536 : h;
      4:       return b;
      5:       return h;
      default: return rd;
    endcase
  endfunction

  function automatic int unsigned model_wdata(input int f3, input int unsigned wd);
    case (f3)
      0:       return (wd & 32'hFF) * 32'h01010101;
      1:       return (wd & 32'hFFFF) * 32'h00010001;
      default: return wd;
    endcase
  endfunction

  function automatic int unsigned model_wmask(input int f3, input int unsigned a);
    case (f3)
      0:       return 1 << (a % 4);
      1:       return 3 << (2 * ((a / 2) % 2));
      default: return 15;
    endcase
  endfunction

  // dly = ACCESS cycle (1-based) in which mem_ready is raised; dly > TMO never raises it.
  task automatic txn(input bit st, input int f3, input int unsigned a, input int unsigned wd,
                     input int unsigned rd, input int dly);
    bit bad;
    bit to;
    bit done;
    int strobes;
    int unsigned e_rd;
    bad  = model_bad(st, f3, a);
    to   = !bad && (dly > TMO);
    e_rd = (bad || to || st) ? 0 : model_load(f3, a, rd);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = 3'(f3);
    req_addr   = a;
    req_wdata  = wd;
    mem_ready  = 1'($urandom_range(0, 1));
    mem_rdata  = $urandom;
    @(negedge CLK);
    req_valid  = 1'b0;
    req_store  = 1'($urandom_range(0, 1));
    req_funct3 = 3'($urandom_range(0, 7));
    req_addr   = $urandom;
    req_wdata  = $urandom;
    mem_ready  = 1'b0;
    strobes    = 0;
    done       = bad;
    for (int k = 1; k <= TMO + 1 && !done; k++) begin
      if (mem_rstrb || mem_wmask != 4'd0) strobes++;
      check("access_mem_addr", mem_addr, (a / 4) * 4);
      check("access_rsp_valid", 32'(rsp_valid), 32'd0);
      if (st) begin
        check("store_wmask", 32'(mem_wmask), model_wmask(f3, a));
        check("store_wdata", mem_wdata, model_wdata(f3, wd));
        check("store_rstrb", 32'(mem_rstrb), 32'd0);
      end else begin
        check("load_rstrb", 32'(mem_rstrb), 32'd1);
        check("load_wmask", 32'(mem_wmask), 32'd0);
      end
      if (k == dly) begin
        mem_ready = 1'b1;
        mem_rdata = rd;
      end else begin
        mem_rdata = $urandom;
      end
      @(negedge CLK);
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      if (rsp_valid) done = 1'b1;
    end
    check("rsp_arrived", 32'(done), 32'd1);
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_err", 32'(rsp_err), 32'(bad || to));
    check("rsp_rdata", rsp_rdata, e_rd);
    check("strobe_cycles", 32'(strobes), bad ? 32'd0 : (to ? 32'(TMO) : 32'(dly)));
    check("resp_rstrb", 32'(mem_rstrb), 32'd0);
    check("resp_wmask", 32'(mem_wmask), 32'd0);
    check("resp_req_ready", 32'(req_ready), 32'd0);
    @(negedge CLK);
    check("rsp_one_cycle", 32'(rsp_valid), 32'd0);
  endtask

  int lf3 [5] = '{0, 1, 2, 4, 5};

  initial begin
    RESET      = 1'b0;
    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    mem_rdata  = 32'd0;
    mem_ready  = 1'b0;
    #1;
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_rstrb", 32'(mem_rstrb), 32'd0);
    check("reset_wmask", 32'(mem_wmask), 32'd0);
    check("reset_mem_addr", mem_addr, 32'd0);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);

    txn(1'b1, 0, 32'h102, 32'h000000AB, 32'h0, 1);
    txn(1'b0, 0, 32'h003, 32'h0, 32'h80FF1234, 1);
    txn(1'b0, 4, 32'h003, 32'h0, 32'h80FF1234, 1);
    txn(1'b0, 5, 32'h002, 32'h0, 32'h80FF1234, 1);
    txn(1'b0, 2, 32'h200, 32'h0, 32'hDEADBEEF, 5);
    txn(1'b0, 2, 32'h300, 32'h0, 32'h12345678, 99);
    txn(1'b1, 1, 32'h402, 32'hCAFE8001, 32'h0, 3);
    txn(1'b0, 2, 32'h101, 32'h0, 32'h0BADF00D, 1);
    txn(1'b1, 2, 32'h103, 32'h11223344, 32'h0, 2);
    txn(1'b0, 1, 32'h001, 32'h0, 32'h8001F00F, 1);
    txn(1'b0, 3, 32'h040, 32'h0, 32'h0, 1);
    txn(1'b1, 4, 32'h040, 32'h55, 32'h0, 1);

    // Reset in the middle of a load: strobes must fall without waiting for a clock edge.
    req_valid  = 1'b1;
    req_store  = 1'b0;
    req_funct3 = 3'd2;
    req_addr   = 32'h0000_0500;
    @(negedge CLK);
    req_valid = 1'b0;
    check("pre_reset_rstrb", 32'(mem_rstrb), 32'd1);
    #2;
    RESET = 1'b0;
    #1;
    check("async_rstrb", 32'(mem_rstrb), 32'd0);
    check("async_wmask", 32'(mem_wmask), 32'd0);
    check("async_mem_addr", mem_addr, 32'd0);
    check("async_rsp_valid", 32'(rsp_valid), 32'd0);
    check("async_req_ready", 32'(req_ready), 32'd1);
    @(negedge CLK);
    RESET = 1'b1;
    mem_ready = 1'b1;
    @(negedge CLK);
    mem_ready = 1'b0;
    check("post_reset_req_ready", 32'(req_ready), 32'd1);
    repeat (3) begin
      check("post_reset_no_rsp", 32'(rsp_valid), 32'd0);
      @(negedge CLK);
    end

    for (int n = 0; n < 40; n++) begin
      bit st;
      int f3;
      int dly;
      st  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) != 0) f3 = st ? int'($urandom_range(0, 2)) : lf3[$urandom_range(0, 4)];
      else f3 = int'($urandom_range(0, 7));
      dly = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(1, 4));
      txn(st, f3, $urandom, $urandom, $urandom, dly);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
